// File: rtl/fetch_sequencer_if.sv
// Bundle of run/handshake inputs and fetch strobes between the sequencer and the datapath.
// master is the sequencer side; slave is the datapath/RAM/execute side.
interface fetch_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             MOC;
    logic             exec_done;
    logic             clear_fault;
    logic             MARld;
    logic             mem_rd;
    logic             IRld;
    logic             exec_start;
    logic             PCld;
    logic             nPCld;
    logic             mem_fault;
    logic [CNT_W-1:0] instr_count;
    logic [2:0]       state;

    // Handshakes are level/pulse based: MOC and exec_done are only looked at
    // in READ and EXEC respectively; every strobe is a Moore decode of state.
    modport master (
        input  run, MOC, exec_done, clear_fault,
        output MARld, mem_rd, IRld, exec_start, PCld, nPCld, mem_fault,
        output instr_count, state
    );

    modport slave (
        output run, MOC, exec_done, clear_fault,
        input  MARld, mem_rd, IRld, exec_start, PCld, nPCld, mem_fault,
        input  instr_count, state
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch control FSM: ADDR -> READ -> LOAD -> EXEC -> UPDATE,
// with a RAM timeout that parks the FSM in FAULT until clear_fault.
module fetch_sequencer #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input logic               clk,
    input logic               rst_n,
    fetch_sequencer_if.master bus
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_READ   = 3'd2,
        S_LOAD   = 3'd3,
        S_EXEC   = 3'd4,
        S_UPDATE = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  instr_count;
    logic              exec_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_cnt    <= '0;
            instr_count <= '0;
            exec_first  <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Marks the first EXEC cycle so exec_start stays a single pulse.
            exec_first <= (state_q == S_LOAD);
            if (state_q == S_ADDR) begin
                wait_cnt <= '0;
            end else if (state_q == S_READ) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state_q == S_UPDATE) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.run) state_d = S_ADDR;
            S_ADDR:   state_d = S_READ;
            S_READ: begin
                // MOC wins over a timeout landing in the same cycle.
                if (bus.MOC) begin
                    state_d = S_LOAD;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_d = S_FAULT;
                end
            end
            S_LOAD:   state_d = S_EXEC;
            S_EXEC:   if (bus.exec_done) state_d = S_UPDATE;
            S_UPDATE: state_d = bus.run ? S_ADDR : S_IDLE;
            S_FAULT:  if (bus.clear_fault) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.MARld      = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.IRld       = 1'b0;
        bus.exec_start = 1'b0;
        bus.PCld       = 1'b0;
        bus.nPCld      = 1'b0;
        bus.mem_fault  = 1'b0;
        case (state_q)
            S_ADDR:   bus.MARld      = 1'b1;
            S_READ:   bus.mem_rd     = 1'b1;
            S_LOAD:   bus.IRld       = 1'b1;
            S_EXEC:   bus.exec_start = exec_first;
            S_UPDATE: begin
                bus.PCld  = 1'b1;
                bus.nPCld = 1'b1;
            end
            S_FAULT:  bus.mem_fault  = 1'b1;
            default:  ;
        endcase
    end

    assign bus.instr_count = instr_count;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle expected state/strobe words go
// through a queue and are compared one cycle at a time, plus the retired count.
module tb_fetch_sequencer;
    localparam int CNT_W = 3;
    localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, READ = 3'd2, LOAD = 3'd3,
                           EXEC = 3'd4, UPDATE = 3'd5, FAULT = 3'd6;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_cnt;
    logic [9:0] exp_q[$];

    fetch_sequencer_if #(.CNT_W(CNT_W)) bus ();

    fetch_sequencer #(.MAX_WAIT(15), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {MARld, mem_rd, IRld, exec_start, PCld, nPCld, mem_fault} for a state.
    function automatic logic [6:0] strobes_for(input logic [2:0] st, input logic xs);
        case (st)
            ADDR:    return 7'b1000000;
            READ:    return 7'b0100000;
            LOAD:    return 7'b0010000;
            EXEC:    return xs ? 7'b0001000 : 7'b0000000;
            UPDATE:  return 7'b0000110;
            FAULT:   return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic push_exp(input logic [2:0] st, input logic xs);
        exp_q.push_back({st, strobes_for(st, xs)});
    endtask

    task automatic check_out(input string tag);
        logic [9:0] obs;
        logic [9:0] exp;
        obs = {bus.state, bus.MARld, bus.mem_rd, bus.IRld, bus.exec_start,
               bus.PCld, bus.nPCld, bus.mem_fault};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h with empty expected queue", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed state/strobes %b expected %b", tag, obs, exp);
            end
        end
    endtask

    task automatic check_cnt(input string tag);
        logic [CNT_W-1:0] exp;
        exp = CNT_W'(exp_cnt);
        checks++;
        assert (bus.instr_count === exp) else begin
            errors++;
            $error("FAIL %s: observed instr_count %0d expected %0d", tag, bus.instr_count, exp);
        end
    endtask

    task automatic step(input logic [2:0] st, input logic xs, input string tag);
        @(posedge clk);
        #1;
        push_exp(st, xs);
        check_out(tag);
    endtask

    task automatic bump_cnt();
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        exp_cnt         = 0;
        rst_n           = 1'b0;
        bus.run         = 1'b0;
        bus.MOC         = 1'b0;
        bus.exec_done   = 1'b0;
        bus.clear_fault = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        push_exp(IDLE, 1'b0);
        check_out("reset_outputs");
        check_cnt("reset_count");
        rst_n = 1'b1;

        // Back-to-back instructions with MOC and exec_done tied high.
        bus.run       = 1'b1;
        bus.MOC       = 1'b1;
        bus.exec_done = 1'b1;
        step(ADDR, 1'b0, "t1_addr");
        for (int i = 0; i < 4; i++) begin
            step(READ, 1'b0, "t1_read");
            step(LOAD, 1'b0, "t1_load");
            step(EXEC, 1'b1, "t1_exec");
            step(UPDATE, 1'b0, "t1_update");
            check_cnt("t1_count_before_retire");
            step(ADDR, 1'b0, "t1_next_addr");
            bump_cnt();
            check_cnt("t1_count");
        end

        // MOC arrives in the fourth READ cycle.
        bus.MOC = 1'b0;
        for (int i = 0; i < 3; i++) step(READ, 1'b0, "t2_read_wait");
        step(READ, 1'b0, "t2_read_moc");
        bus.MOC = 1'b1;
        step(LOAD, 1'b0, "t2_load");
        step(EXEC, 1'b1, "t2_exec");
        step(UPDATE, 1'b0, "t2_update");
        step(ADDR, 1'b0, "t2_next_addr");
        bump_cnt();
        check_cnt("t2_count");

        // MOC never arrives: timeout after 15 READ cycles, stray inputs ignored in FAULT.
        bus.MOC = 1'b0;
        for (int i = 0; i < 15; i++) step(READ, 1'b0, "t3_read");
        step(FAULT, 1'b0, "t3_fault");
        bus.MOC       = 1'b1;
        bus.exec_done = 1'b1;
        step(FAULT, 1'b0, "t3_fault_sticky");
        step(FAULT, 1'b0, "t3_fault_ignores_run");
        check_cnt("t3_count_unchanged");
        bus.MOC         = 1'b0;
        bus.exec_done   = 1'b0;
        bus.clear_fault = 1'b1;
        step(IDLE, 1'b0, "t3_cleared");
        bus.clear_fault = 1'b0;
        step(ADDR, 1'b0, "t3_restart");

        // MOC in the limit cycle beats the timeout.
        for (int i = 0; i < 15; i++) step(READ, 1'b0, "t4_read");
        bus.MOC = 1'b1;
        step(LOAD, 1'b0, "t4_load_at_limit");
        bus.MOC = 1'b0;

        // run dropped during EXEC; exec_done two cycles later.
        step(EXEC, 1'b1, "t5_exec_first");
        bus.run = 1'b0;
        step(EXEC, 1'b0, "t5_exec_wait1");
        step(EXEC, 1'b0, "t5_exec_wait2");
        bus.exec_done = 1'b1;
        step(UPDATE, 1'b0, "t5_update");
        bus.exec_done = 1'b0;
        step(IDLE, 1'b0, "t5_idle");
        bump_cnt();
        check_cnt("t5_count");
        step(IDLE, 1'b0, "t5_no_marld");

        // Two more instructions wrap the narrow counter.
        bus.run       = 1'b1;
        bus.MOC       = 1'b1;
        bus.exec_done = 1'b1;
        step(ADDR, 1'b0, "wrap_addr");
        for (int i = 0; i < 2; i++) begin
            step(READ, 1'b0, "wrap_read");
            step(LOAD, 1'b0, "wrap_load");
            step(EXEC, 1'b1, "wrap_exec");
            step(UPDATE, 1'b0, "wrap_update");
            step(ADDR, 1'b0, "wrap_next_addr");
            bump_cnt();
            check_cnt("wrap_count");
        end

        // Asynchronous reset in EXEC, checked before the next clock edge.
        step(READ, 1'b0, "t6_read");
        step(LOAD, 1'b0, "t6_load");
        bus.exec_done = 1'b0;
        step(EXEC, 1'b1, "t6_exec");
        rst_n = 1'b0;
        #2;
        exp_cnt = 0;
        push_exp(IDLE, 1'b0);
        check_out("t6_async_reset");
        check_cnt("t6_async_count");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(ADDR, 1'b0, "t6_after_reset");
        check_cnt("t6_count_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
